// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, the common baud divider
// and the bit-voting helper used by the receiver's optional majority sampler
// (enabled with UART_RX_MAJORITY_EN in uart_rx).
package uart_pkg;

  // Frame-level states of the receiver; the same encoding is visible on the
  // receiver's debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // System clocks per bit; the transmitter and receiver must agree on it.
  localparam int unsigned UART_BAUD_DIV_DEFAULT = 7292;

  // Payload width of one frame.
  localparam int unsigned UART_DATA_BITS = 8;

  // 2-of-3 vote, used to reject a single-clock glitch at a sample point.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input, plus a
// falling-edge detector on the synchronized value. Every flop resets to 1 so
// that an idle line produces no edge when reset is released.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rx_s,
  output logic start_edge
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-stage synchronizer followed by one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;

  // A falling edge needs a preceding high, so a line held low fires only once.
  assign start_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1: one start bit, eight data bits LSB first, one stop bit.
// Bit timing comes from the system clock and BAUD_RATE_DIV, the same divider
// the transmitter uses.
//
// Build option: define UART_RX_MAJORITY_EN to take every bit sample as the
// 2-of-3 vote of the synchronized line at counter limit-2, limit-1 and limit.
// Without it, each sample is the single value at the counter limit.
//
// Output protocol: there is no ready input. rx_valid pulses for exactly one
// cycle when `data` takes a new byte; the consumer must capture `data` in
// that cycle. `data` then holds until the next good frame overwrites it.
// frame_err pulses for one cycle instead of rx_valid when the stop bit is low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      rx_valid,
  output logic                      rx_busy,
  output logic                      frame_err,
  output uart_state_e               dbg_state
);

  localparam int unsigned HALF_DIV   = BAUD_RATE_DIV / 2;
  localparam logic [15:0] FULL_LIMIT = 16'(BAUD_RATE_DIV - 1);
  localparam logic [15:0] HALF_LIMIT = 16'(HALF_DIV - 1);

  uart_state_e                state;
  logic [15:0]                baud_cnt;
  logic [2:0]                 bit_cnt;
  logic [UART_DATA_BITS-1:0]  shift;
  logic                       rx_s;
  logic                       start_edge;
  logic                       sample_bit;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (rx),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous synchronized values; together with rx_s they form the
  // three-cycle window voted on at each sample point.
  logic [1:0] hist;

  // Shift the synchronized line into the voting window every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample_bit = maj3(hist[1], hist[0], rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // Frame sequencer: start-bit validation at half a bit, then eight data bits
  // and the stop bit, each sampled at its centre.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      shift     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          rx_busy  <= 1'b0;
          if (start_edge) begin
            rx_busy <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_LIMIT) begin
            baud_cnt <= 16'd0;
            if (!sample_bit) begin
              state <= DATA;
            end else begin
              // Line is high again at mid start bit: treat as a glitch.
              rx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA: begin
          if (baud_cnt == FULL_LIMIT) begin
            baud_cnt <= 16'd0;
            shift    <= {sample_bit, shift[UART_DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_LIMIT) begin
            baud_cnt <= 16'd0;
            if (sample_bit) begin
              data     <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            rx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          rx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // FSM state, for observation only.
  assign dbg_state = state;

endmodule
